unidad_busqueda: RTL

Instruction-fetch unit: the requesting side of the `memoriainst` instruction-memory port. It owns the program counter, drives the byte address `dir` to the asynchronous instruction memory, and holds `dir` stable for a fixed number of wait cycles to cover the memory's propagation delay. It then latches `instruccion` into an output register that is handed to decode through a valid/stall handshake. Jump/branch redirects from later stages are applied here.

---
 rtl/unidad_busqueda.sv | 104 ++++++++++
 1 files changed

// File: rtl/unidad_busqueda.sv
`default_nettype none
// ============================================================================
// Module      : unidad_busqueda
// Description : Instruction-fetch unit. Owns the program counter, holds the
//               fetch address stable for WAIT_CYCLES cycles while the
//               asynchronous instruction memory settles, then latches the
//               returned word into a valid/stall output slot for decode.
//               Jump/branch redirects from later stages are applied here.
//               Optional feature macro: UNIDAD_BUSQUEDA_ALIGN_ERR_EN
//               (adds the sticky misaligned-target flag error_alin).
// Revision    : 1.0 - initial release
// ============================================================================
module unidad_busqueda #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] dir,
    input  logic [31:0] instruccion,
    input  logic        stall,
    input  logic        salto,
    input  logic [31:0] dir_salto,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        valida
`ifdef UNIDAD_BUSQUEDA_ALIGN_ERR_EN
    ,
    output logic        error_alin
`endif
);

    // Last value of the wait counter; WAIT_CYCLES is at most 15 so 4 bits suffice.
    localparam logic [3:0] c_CNT_TERM = 4'(WAIT_CYCLES - 1);

    logic [31:0] r_dir;
    logic [31:0] r_inst_out;
    logic [31:0] r_pc_out;
    logic        r_valida;
    logic [3:0]  r_cnt;

    logic        w_term;
    logic        w_slot_free;
    logic        w_complete;

    // The wait has elapsed and decode has room (empty slot or being drained now).
    assign w_term      = (r_cnt == c_CNT_TERM);
    assign w_slot_free = !r_valida || !stall;
    assign w_complete  = w_term && w_slot_free;

    // Fetch sequencing: redirect beats completion, which beats consume/stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dir      <= RESET_PC;
            r_cnt      <= 4'd0;
            r_valida   <= 1'b0;
            r_inst_out <= 32'h0000_0000;
            r_pc_out   <= 32'h0000_0000;
        end else if (salto) begin
            // Flush the held word and restart the wait on the word-aligned target;
            // inst_out/pc_out deliberately keep their stale contents.
            r_dir    <= {dir_salto[31:2], 2'b00};
            r_cnt    <= 4'd0;
            r_valida <= 1'b0;
        end else if (w_complete) begin
            // New word may replace one being consumed on this same edge.
            r_inst_out <= instruccion;
            r_pc_out   <= r_dir;
            r_valida   <= 1'b1;
            r_dir      <= r_dir + 32'd4;
            r_cnt      <= 4'd0;
        end else begin
            // Counter parks at terminal while the slot is busy; dir never moves here.
            if (!w_term) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (r_valida && !stall) begin
                r_valida <= 1'b0;
            end
        end
    end

`ifdef UNIDAD_BUSQUEDA_ALIGN_ERR_EN
    logic r_error_alin;

    // Sticky flag for redirect targets whose low address bits were not zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_error_alin <= 1'b0;
        end else if (salto && (dir_salto[1:0] != 2'b00)) begin
            r_error_alin <= 1'b1;
        end
    end

    assign error_alin = r_error_alin;
`endif

    assign dir      = r_dir;
    assign inst_out = r_inst_out;
    assign pc_out   = r_pc_out;
    assign valida   = r_valida;

endmodule
`default_nettype wire
